// File: rtl/tdes_pkg.sv
// -----------------------------------------------------------------------------
// tdes_pkg
// Shared types and helpers for the Triple-DES pass sequencer.
//   tdes_seq_state_t : sequencer FSM states
//   tdes_pass_t      : pass index (0..2)
//   pass_key_sel()   : maps (encrypt, pass) to the key index and DES core mode
//                      EDE encrypt : K1/E, K2/D, K3/E
//                      DED decrypt : K3/D, K2/E, K1/D
// -----------------------------------------------------------------------------
package tdes_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } tdes_seq_state_t;

   typedef logic [1:0] tdes_pass_t;

   localparam tdes_pass_t TDES_LAST_PASS = 2'd2;

   localparam logic DES_MODE_ENC = 1'b1;
   localparam logic DES_MODE_DEC = 1'b0;

   // key_idx is 1, 2 or 3 (key1/key2/key3)
   typedef logic [1:0] tdes_key_idx_t;

   typedef struct packed {
      tdes_key_idx_t key_idx;
      logic          mode;
   } tdes_pass_sel_t;

   function automatic tdes_pass_sel_t pass_key_sel(input logic encrypt, input tdes_pass_t pass);
      tdes_pass_sel_t sel;
      case (pass)
         2'd0: begin
            sel.key_idx = encrypt ? 2'd1 : 2'd3;
            sel.mode    = encrypt ? DES_MODE_ENC : DES_MODE_DEC;
         end
         2'd1: begin
            sel.key_idx = 2'd2;
            sel.mode    = encrypt ? DES_MODE_DEC : DES_MODE_ENC;
         end
         // pass 2; the unused code 3 shares it so the mapping stays total
         default: begin
            sel.key_idx = encrypt ? 2'd3 : 2'd1;
            sel.mode    = encrypt ? DES_MODE_ENC : DES_MODE_DEC;
         end
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/tdes_watchdog.sv
// -----------------------------------------------------------------------------
// tdes_watchdog
// Per-pass cycle counter for the Triple-DES pass sequencer. Saturates at
// TIMEOUT_CYCLES-1 and never wraps.
// Ports:
//   HCLK      in  clock, rising edge
//   HRESET    in  asynchronous, active-low reset
//   clear     in  synchronous clear (takes priority over count_en)
//   count_en  in  increment by one this cycle
//   expired   out count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module tdes_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic HCLK,
   input  logic HRESET,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en && (count != CNT_LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == CNT_LAST);

endmodule

// File: rtl/tdes_pass_sequencer.sv
// -----------------------------------------------------------------------------
// tdes_pass_sequencer
// Drives one shared single-DES core through the three passes of Triple DES
// (EDE encrypt / DED decrypt), with a per-pass watchdog and abort on bus error.
// Ports:
//   HCLK, HRESET           clock (rising) / asynchronous active-low reset
//   enable                 start request, sampled every cycle
//   encryptionType         1 = encrypt (EDE), 0 = decrypt (DED)
//   data, key1..key3       input block and DES keys (latched on acceptance)
//   abort                  bus error; kills the job in flight
//   des_done, des_out      core result valid pulse / core result
//   des_start              core launch pulse
//   des_encrypt, des_key,
//   des_in                 core mode, key and input block for the current pass
//   outputEnable           final result valid, 1-cycle pulse
//   outputData             final result, held until the next completion
//   busy                   high in every state except IDLE
//   timeout_err            sticky watchdog flag, cleared on the next accepted job
//   start_dropped          enable seen while busy and ignored
// -----------------------------------------------------------------------------
module tdes_pass_sequencer
   import tdes_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        enable,
   input  logic        encryptionType,
   input  logic [63:0] data,
   input  logic [63:0] key1,
   input  logic [63:0] key2,
   input  logic [63:0] key3,
   input  logic        abort,
   input  logic        des_done,
   input  logic [63:0] des_out,
   output logic        des_start,
   output logic        des_encrypt,
   output logic [63:0] des_key,
   output logic [63:0] des_in,
   output logic        outputEnable,
   output logic [63:0] outputData,
   output logic        busy,
   output logic        timeout_err,
   output logic        start_dropped
);

   tdes_seq_state_t state;
   tdes_pass_t      pass;
   logic            enc_reg;
   logic [63:0]     data_reg;
   logic [63:0]     key1_reg;
   logic [63:0]     key2_reg;
   logic [63:0]     key3_reg;
   logic [63:0]     work_reg;
   logic            wd_expired;
   tdes_pass_sel_t  sel;

   tdes_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .HCLK    (HCLK),
      .HRESET  (HRESET),
      .clear   (state == LAUNCH),
      .count_en(state == WAIT),
      .expired (wd_expired)
   );

   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         state        <= IDLE;
         pass         <= '0;
         enc_reg      <= 1'b0;
         data_reg     <= '0;
         key1_reg     <= '0;
         key2_reg     <= '0;
         key3_reg     <= '0;
         work_reg     <= '0;
         timeout_err  <= 1'b0;
         outputEnable <= 1'b0;
         outputData   <= '0;
      end else begin
         outputEnable <= 1'b0;
         case (state)
            IDLE: begin
               // abort in IDLE vetoes acceptance of a simultaneous enable
               if (enable && !abort) begin
                  enc_reg     <= encryptionType;
                  data_reg    <= data;
                  key1_reg    <= key1;
                  key2_reg    <= key2;
                  key3_reg    <= key3;
                  pass        <= '0;
                  timeout_err <= 1'b0;
                  state       <= LAUNCH;
               end
            end
            LAUNCH: begin
               state <= abort ? IDLE : WAIT;
            end
            WAIT: begin
               // priority: abort, then des_done (beats a watchdog expiring
               // on the same cycle), then timeout
               if (abort) begin
                  state <= IDLE;
               end else if (des_done) begin
                  work_reg <= des_out;
                  if (pass == TDES_LAST_PASS) begin
                     state <= DONE;
                  end else begin
                     pass  <= pass + 2'd1;
                     state <= LAUNCH;
                  end
               end else if (wd_expired) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end
            end
            DONE: begin
               if (!abort) begin
                  outputEnable <= 1'b1;
                  outputData   <= work_reg;
               end
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      sel         = pass_key_sel(enc_reg, pass);
      des_encrypt = sel.mode;
      case (sel.key_idx)
         2'd1:    des_key = key1_reg;
         2'd2:    des_key = key2_reg;
         default: des_key = key3_reg;
      endcase
      des_in = (pass == 2'd0) ? data_reg : work_reg;
   end

   assign des_start     = (state == LAUNCH);
   assign busy          = (state != IDLE);
   assign start_dropped = enable && busy;

endmodule
